// File: rtl/dma_burst_arbiter.sv
// dma_burst_arbiter
// Round-robin arbiter that drains N show-ahead requester FIFOs into one
// Avalon-MM burst write master. Each channel writes a linear region that
// starts at its base address and advances by 16 bytes per beat.
//
// Ports
//   c               : clock, everything on the rising edge
//   rst_n           : asynchronous active-low reset
//   clear           : one-cycle pulse, return all channel pointers to base
//   flush           : level, also allow bursts shorter than BURST
//   flush_complete  : registered, flush requested and every FIFO is empty
//   in_q            : N x 128-bit FIFO heads (channel 0 in the LSBs)
//   in_cnt          : N x 7-bit FIFO used-word counts
//   in_rdreq        : N pop strobes, one-hot or zero
//   txs_*           : Avalon-MM burst write master
//
// A channel's in_cnt must not drop below the remaining beats of its burst
// while that burst is in flight; the block does not guard against it.
module dma_burst_arbiter #(
  parameter int N = 5,
  parameter int AW = 23,
  parameter int BURST = 32,
  parameter logic [N*AW-1:0] BASE_ADDRS = {23'h400000, 23'h300000, 23'h200000,
                                           23'h100000, 23'h000000}
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              flush,
  output logic              flush_complete,
  input  logic [N*128-1:0]  in_q,
  input  logic [N*7-1:0]    in_cnt,
  output logic [N-1:0]      in_rdreq,
  input  logic              txs_waitrequest,
  output logic              txs_write,
  output logic [127:0]      txs_writedata,
  output logic [5:0]        txs_burstcount,
  output logic [AW-1:0]     txs_address
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0]    BURST_CNT = 7'(BURST);
  localparam logic [5:0]    BURST_LEN = 6'(BURST);
  localparam logic [IW-1:0] LAST_CH   = IW'(N - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [IW-1:0]   r_sel;
  logic [5:0]      r_len;
  logic [5:0]      r_beat;
  logic [AW-1:0]   r_ptr [N];
  logic [IW-1:0]   r_rr;
  logic            r_clr_pend;
  logic            r_write;
  logic [5:0]      r_burstcount;
  logic [AW-1:0]   r_address;
  logic            r_flush_complete;

  logic [N-1:0]    w_elig;
  logic            w_any_data;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;
  logic [6:0]      w_win_cnt;
  logic [5:0]      w_win_len;
  logic            w_accept;
  logic            w_last_beat;

  // Channel index base+off folded back into 0..N-1 (off is always < N).
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(32'(base)) + off;
    if (sum >= N) begin
      sum = sum - N;
    end else begin
      sum = sum;
    end
    return IW'(sum);
  endfunction

  // Per-channel eligibility: a full burst is waiting, or flush drains leftovers.
  always_comb begin
    w_elig     = '0;
    w_any_data = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_elig[i]  = (in_cnt[i*7 +: 7] >= BURST_CNT) ||
                   (flush && (in_cnt[i*7 +: 7] != 7'd0));
      w_any_data = w_any_data | (in_cnt[i*7 +: 7] != 7'd0);
    end
  end

  // Round-robin search: first eligible channel at or after r_rr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = wrap_idx(r_rr, k);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Burst length of the winner: min(in_cnt, BURST). Below BURST it fits 6 bits.
  always_comb begin
    w_win_cnt = in_cnt[32'(w_win)*7 +: 7];
    if (w_win_cnt >= BURST_CNT) begin
      w_win_len = BURST_LEN;
    end else begin
      w_win_len = w_win_cnt[5:0];
    end
  end

  assign w_accept    = (r_state == ST_BURST) && !txs_waitrequest;
  assign w_last_beat = w_accept && (r_beat == (r_len - 6'd1));

  // FSM state register.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; a clear in ST_ARB throws away that cycle's grant.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ARB: begin
        if (!clear && w_found) begin
          w_next_state = ST_BURST;
        end else begin
          w_next_state = ST_ARB;
        end
      end
      ST_BURST: begin
        if (w_last_beat) begin
          w_next_state = ST_ARB;
        end else begin
          w_next_state = ST_BURST;
        end
      end
      default: w_next_state = ST_ARB;
    endcase
  end

  // FSM outputs: pop strobe in the accepting cycle, data straight from the FIFO head.
  always_comb begin
    in_rdreq      = '0;
    txs_writedata = '0;
    case (r_state)
      ST_BURST: begin
        txs_writedata = in_q[32'(r_sel)*128 +: 128];
        if (w_accept) begin
          in_rdreq = N'(1'b1) << r_sel;
        end else begin
          in_rdreq = '0;
        end
      end
      default: begin
        in_rdreq      = '0;
        txs_writedata = '0;
      end
    endcase
  end

  // Datapath: grant latch, beat counting, pointer/round-robin update, clear handling.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_sel            <= '0;
      r_len            <= 6'd0;
      r_beat           <= 6'd0;
      r_rr             <= '0;
      r_clr_pend       <= 1'b0;
      r_write          <= 1'b0;
      r_burstcount     <= 6'd0;
      r_address        <= '0;
      r_flush_complete <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_ptr[i] <= BASE_ADDRS[i*AW +: AW];
      end
    end else begin
      r_flush_complete <= flush && (r_state == ST_ARB) && !w_any_data;
      case (r_state)
        ST_ARB: begin
          r_beat <= 6'd0;
          if (clear) begin
            r_rr       <= '0;
            r_clr_pend <= 1'b0;
            r_write    <= 1'b0;
            for (int i = 0; i < N; i++) begin
              r_ptr[i] <= BASE_ADDRS[i*AW +: AW];
            end
          end else if (w_found) begin
            r_sel        <= w_win;
            r_len        <= w_win_len;
            r_write      <= 1'b1;
            r_burstcount <= w_win_len;
            r_address    <= r_ptr[w_win];
          end else begin
            r_write <= 1'b0;
          end
        end
        ST_BURST: begin
          if (w_last_beat) begin
            r_write      <= 1'b0;
            r_burstcount <= 6'd0;
            r_address    <= '0;
            r_beat       <= 6'd0;
            r_clr_pend   <= 1'b0;
            // A clear seen at any point of the burst replaces the normal advance.
            if (clear || r_clr_pend) begin
              r_rr <= '0;
              for (int i = 0; i < N; i++) begin
                r_ptr[i] <= BASE_ADDRS[i*AW +: AW];
              end
            end else begin
              r_ptr[r_sel] <= r_ptr[r_sel] + AW'({r_len, 4'b0000});
              if (r_sel == LAST_CH) begin
                r_rr <= '0;
              end else begin
                r_rr <= r_sel + IW'(1);
              end
            end
          end else begin
            if (w_accept) begin
              r_beat <= r_beat + 6'd1;
            end else begin
              r_beat <= r_beat;
            end
            if (clear) begin
              r_clr_pend <= 1'b1;
            end else begin
              r_clr_pend <= r_clr_pend;
            end
          end
        end
        default: begin
          r_write <= 1'b0;
          r_beat  <= 6'd0;
        end
      endcase
    end
  end

  assign txs_write      = r_write;
  assign txs_burstcount = r_burstcount;
  assign txs_address    = r_address;
  assign flush_complete = r_flush_complete;

endmodule

// File: tb/tb_dma_burst_arbiter.sv
// Self-checking bench for dma_burst_arbiter. The FIFOs are modelled as counts
// plus a per-channel sequence number that determines the head word; the
// reference model predicts each cycle's bus outputs from the arbitration rules.
module tb_dma_burst_arbiter;

  localparam int N = 5;
  localparam int AW = 23;
  localparam int BURST = 32;
  localparam logic [N*AW-1:0] BASES = {23'h7FFFF0, 23'h030000, 23'h020000,
                                      23'h010000, 23'h000000};

  logic              c = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              flush;
  logic              flush_complete;
  logic [N*128-1:0]  in_q;
  logic [N*7-1:0]    in_cnt;
  logic [N-1:0]      in_rdreq;
  logic              txs_waitrequest;
  logic              txs_write;
  logic [127:0]      txs_writedata;
  logic [5:0]        txs_burstcount;
  logic [AW-1:0]     txs_address;

  always #5 c = ~c;

  dma_burst_arbiter #(.N(N), .AW(AW), .BURST(BURST), .BASE_ADDRS(BASES)) dut (
    .c(c), .rst_n(rst_n), .clear(clear), .flush(flush),
    .flush_complete(flush_complete), .in_q(in_q), .in_cnt(in_cnt),
    .in_rdreq(in_rdreq), .txs_waitrequest(txs_waitrequest),
    .txs_write(txs_write), .txs_writedata(txs_writedata),
    .txs_burstcount(txs_burstcount), .txs_address(txs_address)
  );

  int n_tests = 0;
  int n_fail = 0;

  int          f_cnt [N];
  int unsigned f_seq [N];

  bit            m_busy;
  int            m_sel, m_len, m_beat, m_rr;
  bit            m_clr_pend, m_fc;
  logic [AW-1:0] m_ptr [N];

  logic [AW-1:0] log_addr [$];
  int            log_len [$];
  int            obs_pops [N];
  bit            prev_write;
  bit            fc_seen;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] head_data(input int ch, input int unsigned seq);
    return {32'hC0DE_0000 + 32'(ch), seq, ~seq, seq ^ 32'h5A5A_A5A5};
  endfunction

  function automatic logic [AW-1:0] base_of(input int ch);
    logic [N*AW-1:0] b;
    b = BASES;
    return b[ch*AW +: AW];
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_rr = 0; m_clr_pend = 1'b0; m_fc = 1'b0;
    m_sel = 0; m_len = 0; m_beat = 0;
    for (int i = 0; i < N; i++) m_ptr[i] = base_of(i);
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_len.delete(); fc_seen = 1'b0;
    for (int i = 0; i < N; i++) obs_pops[i] = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_cnt[i*7 +: 7]   = 7'(f_cnt[i]);
      in_q[i*128 +: 128] = head_data(i, f_seq[i]);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cyc(input bit wr, input bit clr);
    logic [N-1:0] exp_rd;
    bit all_zero;
    int win;
    txs_waitrequest = wr;
    clear = clr;
    drive_inputs();
    #1;
    if (txs_write === 1'b1 && !prev_write) begin
      log_addr.push_back(txs_address);
      log_len.push_back(int'(txs_burstcount));
    end
    prev_write = (txs_write === 1'b1);
    for (int i = 0; i < N; i++) if (in_rdreq[i] === 1'b1) obs_pops[i]++;
    if (flush_complete === 1'b1) fc_seen = 1'b1;

    chk("txs_write", 128'(txs_write), 128'(m_busy));
    chk("flush_complete", 128'(flush_complete), 128'(m_fc));
    exp_rd = '0;
    if (m_busy) begin
      chk("burstcount", 128'(txs_burstcount), 128'(m_len));
      chk("address", 128'(txs_address), 128'(m_ptr[m_sel]));
      chk("writedata", txs_writedata, head_data(m_sel, f_seq[m_sel]));
      if (!wr) exp_rd[m_sel] = 1'b1;
      if (f_cnt[m_sel] < m_len - m_beat) begin
        n_fail++;
        $error("FAIL illegal_cnt ch=%0d cnt=%0d remaining=%0d", m_sel, f_cnt[m_sel], m_len - m_beat);
      end
    end
    chk("in_rdreq", 128'(in_rdreq), 128'(exp_rd));

    all_zero = 1'b1;
    for (int i = 0; i < N; i++) if (f_cnt[i] != 0) all_zero = 1'b0;
    if (!m_busy) begin
      m_fc = flush && all_zero;
      if (clr) begin
        for (int i = 0; i < N; i++) m_ptr[i] = base_of(i);
        m_rr = 0; m_clr_pend = 1'b0;
      end else begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          int ch;
          ch = (m_rr + k) % N;
          if (win < 0 && (f_cnt[ch] >= BURST || (flush && f_cnt[ch] > 0))) win = ch;
        end
        if (win >= 0) begin
          m_busy = 1'b1; m_sel = win; m_beat = 0;
          m_len = (f_cnt[win] >= BURST) ? BURST : f_cnt[win];
        end
      end
    end else begin
      m_fc = 1'b0;
      if (clr) m_clr_pend = 1'b1;
      if (!wr) begin
        f_cnt[m_sel]--; f_seq[m_sel]++; m_beat++;
        if (m_beat == m_len) begin
          m_busy = 1'b0;
          if (m_clr_pend) begin
            for (int i = 0; i < N; i++) m_ptr[i] = base_of(i);
            m_rr = 0; m_clr_pend = 1'b0;
          end else begin
            m_ptr[m_sel] = AW'((longint'(m_ptr[m_sel]) + m_len * 16) % (longint'(1) << AW));
            m_rr = (m_sel + 1) % N;
          end
        end
      end
    end
    @(posedge c);
    #1;
  endtask

  initial begin
    bit done;
    int stalls;
    rst_n = 1'b0; clear = 1'b0; flush = 1'b1; txs_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) begin f_cnt[i] = 0; f_seq[i] = 32'(i) * 32'h1000; end
    f_cnt[0] = 40;
    drive_inputs();
    model_reset();
    prev_write = 1'b0;
    clear_logs();

    // Reset state, even with an eligible channel and flush present.
    repeat (3) @(posedge c);
    #1;
    chk("rst_write", 128'(txs_write), 128'(1'b0));
    chk("rst_burstcount", 128'(txs_burstcount), 128'(6'd0));
    chk("rst_address", 128'(txs_address), 128'(23'd0));
    chk("rst_rdreq", 128'(in_rdreq), 128'(5'd0));
    chk("rst_flush_complete", 128'(flush_complete), 128'(1'b0));
    f_cnt[0] = 0; flush = 1'b0;
    drive_inputs();
    rst_n = 1'b1;

    // Single full burst on ch0, then a second one at +0x200.
    f_cnt[0] = 32;
    repeat (36) cyc(1'b0, 1'b0);
    chk("s1_nbursts", 128'(log_addr.size()), 128'(1));
    if (log_addr.size() >= 1) begin
      chk("s1_addr0", 128'(log_addr[0]), 128'(23'h000000));
      chk("s1_len0", 128'(log_len[0]), 128'(32));
    end
    chk("s1_pops", 128'(obs_pops[0]), 128'(32));
    f_cnt[0] = 32;
    repeat (36) cyc(1'b0, 1'b0);
    if (log_addr.size() >= 2) chk("s1_addr1", 128'(log_addr[1]), 128'(23'h000200));
    else chk("s1_nbursts2", 128'(log_addr.size()), 128'(2));

    // ch1 and ch3 alternate.
    clear_logs();
    f_cnt[1] = 64; f_cnt[3] = 64;
    repeat (140) cyc(1'b0, 1'b0);
    chk("s2_nbursts", 128'(log_addr.size()), 128'(4));
    if (log_addr.size() >= 4) begin
      chk("s2_b0", 128'(log_addr[0]), 128'(23'h010000));
      chk("s2_b1", 128'(log_addr[1]), 128'(23'h030000));
      chk("s2_b2", 128'(log_addr[2]), 128'(23'h010200));
      chk("s2_b3", 128'(log_addr[3]), 128'(23'h030200));
    end

    // Flush a short ch2 backlog.
    clear_logs();
    flush = 1'b1; f_cnt[2] = 5;
    repeat (10) cyc(1'b0, 1'b0);
    if (log_len.size() >= 1) chk("s3_len", 128'(log_len[0]), 128'(5));
    else chk("s3_nbursts", 128'(log_len.size()), 128'(1));
    chk("s3_pops", 128'(obs_pops[2]), 128'(5));
    chk("s3_fc_seen", 128'(fc_seen), 128'(1'b1));
    flush = 1'b0;
    cyc(1'b0, 1'b0);

    // 10-cycle stall at beat 7 of a ch0 burst.
    clear_logs();
    f_cnt[0] = 32; stalls = 0;
    for (int k = 0; k < 50; k++) begin
      bit wr;
      wr = m_busy && (m_beat == 7) && (stalls < 10);
      if (wr) stalls++;
      cyc(wr, 1'b0);
    end
    chk("s4_pops", 128'(obs_pops[0]), 128'(32));
    if (log_addr.size() >= 1) chk("s4_addr", 128'(log_addr[0]), 128'(23'h000400));

    // Clear at beat 10: burst completes, then ch0 restarts at base.
    clear_logs();
    f_cnt[0] = 32; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bit clr;
      clr = m_busy && (m_beat == 10) && !done;
      if (clr) done = 1'b1;
      cyc(1'b0, clr);
    end
    chk("s5_pops", 128'(obs_pops[0]), 128'(32));
    if (log_len.size() >= 1) chk("s5_len", 128'(log_len[0]), 128'(32));
    f_cnt[0] = 32;
    repeat (36) cyc(1'b0, 1'b0);
    if (log_addr.size() >= 2) chk("s5_addr_after_clear", 128'(log_addr[1]), 128'(23'h000000));
    else chk("s5_nbursts", 128'(log_addr.size()), 128'(2));

    // Clear during arbitration discards the grant.
    f_cnt[1] = 32;
    cyc(1'b0, 1'b1);
    repeat (36) cyc(1'b0, 1'b0);

    // ch4 pointer wraps past 2^AW.
    clear_logs();
    flush = 1'b1; f_cnt[4] = 1;
    repeat (5) cyc(1'b0, 1'b0);
    f_cnt[4] = 1;
    repeat (5) cyc(1'b0, 1'b0);
    flush = 1'b0;
    if (log_addr.size() >= 2) begin
      chk("s6_addr_top", 128'(log_addr[0]), 128'(23'h7FFFF0));
      chk("s6_addr_wrap", 128'(log_addr[1]), 128'(23'h000000));
    end else chk("s6_nbursts", 128'(log_addr.size()), 128'(2));

    // Reset in the middle of a burst.
    f_cnt[1] = 40;
    for (int k = 0; k < 10 && !(m_busy && m_beat == 3); k++) cyc(1'b0, 1'b0);
    chk("s7_in_burst", 128'(txs_write), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("s7_abort_write", 128'(txs_write), 128'(1'b0));
    chk("s7_abort_rdreq", 128'(in_rdreq), 128'(5'd0));
    chk("s7_abort_bc", 128'(txs_burstcount), 128'(6'd0));
    chk("s7_abort_addr", 128'(txs_address), 128'(23'd0));
    model_reset();
    prev_write = 1'b0;
    repeat (2) @(posedge c);
    #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7, 0) == 0) begin
        int ch;
        ch = int'($urandom_range(N - 1, 0));
        f_cnt[ch] = f_cnt[ch] + int'($urandom_range(40, 1));
        if (f_cnt[ch] > 127) f_cnt[ch] = 127;
      end
      if ($urandom_range(49, 0) == 0) flush = ~flush;
      cyc($urandom_range(3, 0) == 0, $urandom_range(59, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_burst_arbiter.md
DMA_BURST_ARBITER -- requirements
Module: dma_burst_arbiter

Interface
REQ-001 SHALL have parameter N, default 5, meaning the number of requester FIFOs.
REQ-002 SHALL have parameter AW, default 23, meaning the txs byte-address width.
REQ-003 SHALL have parameter BURST, default 32, meaning the maximum beats per burst (at most 63).
REQ-004 SHALL have parameter BASE_ADDRS, width N*AW, meaning the per-channel region base byte addresses (channel 0 in the LSBs).
REQ-005 SHALL have port c, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous pulse that returns all channel pointers to base.
REQ-008 SHALL have port flush, input, 1 bit: level request to drain partial FIFO contents.
REQ-009 SHALL have port flush_complete, output, 1 bit: flush done.
REQ-010 SHALL have port in_q, input, N*128 bits: show-ahead FIFO heads.
REQ-011 SHALL have port in_cnt, input, N*7 bits: FIFO read-side used-word counts.
REQ-012 SHALL have port in_rdreq, output, N bits: FIFO pop strobes.
REQ-013 SHALL have port txs_waitrequest, input, 1 bit: Avalon-MM stall.
REQ-014 SHALL have port txs_write, output, 1 bit: Avalon-MM write.
REQ-015 SHALL have port txs_writedata, output, 128 bits: Avalon-MM write data.
REQ-016 SHALL have port txs_burstcount, output, 6 bits: Avalon-MM burst count.
REQ-017 SHALL have port txs_address, output, AW bits: Avalon-MM byte address.

Function
REQ-018 SHALL implement states ST_ARB and ST_BURST, with ST_ARB entered on reset.
REQ-019 In ST_ARB, channel i SHALL be eligible when in_cnt[i] >= BURST, or when flush=1 and in_cnt[i] > 0.
REQ-020 Arbitration SHALL be round-robin: the search starts at rr_ptr, and the lowest eligible index at or after rr_ptr (modulo N) wins.
REQ-021 On a win, the block SHALL latch sel, latch len = min(in_cnt[sel], BURST), and enter ST_BURST on the next cycle; grant latency is 1 cycle from ST_ARB sampling to txs_write=1.
REQ-022 In ST_BURST, txs_write SHALL be 1.
REQ-023 In ST_BURST, txs_burstcount SHALL equal len and txs_address SHALL equal ptr[sel], both held constant for the whole burst.
REQ-024 In ST_BURST, txs_writedata SHALL be a combinational mux of in_q[sel].
REQ-025 A beat SHALL be accepted in a cycle where txs_write=1 and txs_waitrequest=0; on acceptance in_rdreq[sel] pulses in that same cycle and the beat counter increments.
REQ-026 in_rdreq SHALL be zero in every other cycle and never have more than one bit set.
REQ-027 If txs_waitrequest=1, all outputs SHALL hold and no pop SHALL occur, for any stall length.
REQ-028 After the len-th accepted beat: ptr[sel] += len*16, modulo 2^AW; rr_ptr = sel+1, wrapping N-1 to 0; state returns to ST_ARB.
REQ-029 Back-to-back bursts SHALL have at least one ST_ARB cycle (txs_write=0) between them.
REQ-030 flush_complete SHALL be a registered output equal to 1 when flush=1, state=ST_ARB and no in_cnt is nonzero; otherwise 0.
REQ-031 flush deasserted mid-burst SHALL not alter the current burst.
REQ-032 clear in ST_ARB SHALL set every ptr[i] to BASE_ADDRS[i] and rr_ptr to 0 on the next edge; any arbitration decision in that cycle is discarded.
REQ-033 clear in ST_BURST SHALL be latched as pending, the burst SHALL complete unmodified, and the clear SHALL be applied at the burst end instead of the REQ-028 pointer update.
REQ-034 clear coincident with the final beat SHALL be treated as in REQ-033.
REQ-035 An in_cnt decrease below len during a burst is illegal input; the design need not handle it, and the bench SHALL flag it.

Reset
REQ-036 While rst_n=0: state=ST_ARB, txs_write=0, txs_burstcount=0, txs_address=0, in_rdreq=0, flush_complete=0, rr_ptr=0, ptr[i]=BASE_ADDRS[i], clear-pending=0.
REQ-037 Reset asserted mid-burst SHALL abort immediately to the REQ-036 values.
REQ-038 Reset removal SHALL be synchronized externally; the first ST_ARB sample occurs on the first edge after release.

Verification
REQ-039 Scenario: ch0 in_cnt=32, others 0, no stall -> one burst at address 0x000000, burstcount 32, 32 pops; next burst address 0x000200.
REQ-040 Scenario: ch1 and ch3 both in_cnt=64 -> bursts alternate ch1, ch3, ch1, ch3; ch1 addresses BASE1, BASE1+0x200.
REQ-041 Scenario: ch2 in_cnt=5, flush=1 -> burstcount 5, then ch2 in_cnt=0, then flush_complete=1 within 2 cycles.
REQ-042 Scenario: txs_waitrequest=1 for 10 cycles at beat 7 -> data, address and burstcount stable; exactly 32 pops total.
REQ-043 Scenario: clear pulse at beat 10 of a ch0 burst -> burst finishes with 32 beats; next ch0 address = BASE0.
REQ-044 Scenario: ptr[4]=0x7FFFF0 with len=1 -> next ptr[4]=0x000000; rst_n low mid-burst -> txs_write=0 immediately.
